// File: rtl/seg_scroller.sv
// Marquee text source: buffers an ASCII message from a valid/ready stream and scrolls a
// four-character window across it. Define SEG_SCROLLER_GAP_EN to insert four blanks between repeats.
module seg_scroller #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       wr_last,
  output logic       busy,
  output logic [7:0] display_0,
  output logic [7:0] display_1,
  output logic [7:0] display_2,
  output logic [7:0] display_3,
  output logic [1:0] decplace
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 4) + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);
`ifdef SEG_SCROLLER_GAP_EN
  localparam int unsigned GapLen = 4;
`else
  localparam int unsigned GapLen = 0;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StScroll} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   off_q, off_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            busy_q, busy_d;
  logic [7:0]      disp_q [4];
  logic [7:0]      disp_d [4];
  logic [7:0]      mem_q  [DEPTH];
  logic [LW-1:0]   vlen_q, vlen_d, idx;
  logic            accept, static_win;

  assign wr_ready = !clear && (state_q != StScroll) && (len_q < LW'(DEPTH));
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    pre_d   = pre_q;
    vlen_q  = len_q + LW'(GapLen);
    if (clear) begin
      state_d = StIdle;
      len_d   = '0;
      off_d   = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            len_d   = len_q + 1'b1;
            state_d = StLoad;
            // A full buffer ends the message just like wr_last.
            if (wr_last || (len_d == LW'(DEPTH))) begin
              state_d = StScroll;
              off_d   = '0;
              pre_d   = PW'(TICK_DIV - 1);
            end
          end
        end
        StScroll: begin
          if (pre_q == '0) begin
            pre_d = PW'(TICK_DIV - 1);
            if (vlen_q > LW'(4)) begin
              off_d = (off_q == vlen_q - 1'b1) ? '0 : off_q + 1'b1;
            end
          end else begin
            pre_d = pre_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d == StScroll);
  end

  // Window is computed from next-state values; the character written this cycle is bypassed
  // because it is not yet in mem_q on the entry edge.
  always_comb begin
    vlen_d     = len_d + LW'(GapLen);
    static_win = (vlen_d <= LW'(4));
    idx        = '0;
    for (int k = 0; k < 4; k++) begin
      disp_d[k] = 8'h20;
      if (state_d == StScroll) begin
        if (static_win) begin
          idx = LW'(k);
        end else begin
          idx = off_d + LW'(k);
          if (idx >= vlen_d) idx = idx - vlen_d;
        end
        if (idx < len_d) begin
          disp_d[k] = (accept && (idx == len_q)) ? wr_char : mem_q[idx[AW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      off_q   <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      for (int k = 0; k < 4; k++) disp_q[k] <= 8'h20;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      for (int k = 0; k < 4; k++) disp_q[k] <= disp_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[len_q[AW-1:0]] <= wr_char;
  end

  assign busy      = busy_q;
  assign display_0 = disp_q[0];
  assign display_1 = disp_q[1];
  assign display_2 = disp_q[2];
  assign display_3 = disp_q[3];
  assign decplace  = 2'b00;

endmodule

// File: tb/tb_seg_scroller.sv
// Self-checking bench for seg_scroller: directed scenarios plus randomized messages checked
// against a cycle-count reference model of the marquee.
module tb_seg_scroller;
  localparam int D = 16;
  localparam int T = 4;
`ifdef SEG_SCROLLER_GAP_EN
  localparam int Gap = 4;
`else
  localparam int Gap = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_last = 1'b0;
  logic [7:0] wr_char = 8'h00;
  logic       wr_ready, busy;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic [1:0] decplace;

  seg_scroller #(.DEPTH(D), .TICK_DIV(T)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .wr_last(wr_last), .busy(busy), .display_0(display_0),
    .display_1(display_1), .display_2(display_2), .display_3(display_3), .decplace(decplace)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the stored message, whether it is scrolling, and cycles since entry.
  byte unsigned msg[$];
  bit           scroll = 0;
  int           t = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input int k);
    int l, off, idx;
    if (!scroll) return 8'h20;
    l   = msg.size() + Gap;
    off = (l > 4) ? (t / T) % l : 0;
    idx = (l <= 4) ? k : (off + k) % l;
    return (idx < msg.size()) ? msg[idx] : 8'h20;
  endfunction

  task automatic check_outputs();
    check_eq("busy", {31'd0, busy}, {31'd0, scroll});
    check_eq("decplace", {30'd0, decplace}, 32'd0);
    check_eq("display_0", {24'd0, display_0}, {24'd0, exp_char(0)});
    check_eq("display_1", {24'd0, display_1}, {24'd0, exp_char(1)});
    check_eq("display_2", {24'd0, display_2}, {24'd0, exp_char(2)});
    check_eq("display_3", {24'd0, display_3}, {24'd0, exp_char(3)});
  endtask

  // Called #1 after a rising edge; applies inputs for one clock and advances the model.
  task automatic cycle(input bit c, input bit v, input logic [7:0] ch, input bit last);
    bit exp_ready;
    clear = c; wr_valid = v; wr_char = ch; wr_last = last;
    #1;
    exp_ready = !c && !scroll && (msg.size() < D);
    check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (c) begin
      msg.delete();
      scroll = 0;
    end else if (v && exp_ready) begin
      msg.push_back(ch);
      if (last || msg.size() == D) begin
        scroll = 1;
        t = 0;
      end
    end else if (scroll) begin
      t++;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0);
  endtask

  task automatic send(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) cycle(0, 1, s[i], last && (i == s.len() - 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 0; wr_valid = 0; wr_last = 0;
    msg.delete();
    scroll = 0;
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset behaviour
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Scrolling message; further writes must be refused while scrolling
    send("HELLO", 1);
    for (int i = 0; i < 24; i++) cycle(0, 1'($urandom_range(0, 1)), 8'h5A, 0);
    cycle(1, 0, 8'h00, 0);

    // Short message stays static
    send("12", 1);
    idle(20);
    cycle(1, 0, 8'h00, 0);

    // Full buffer without wr_last, then a 17th write attempt
    for (int i = 0; i < D; i++) cycle(0, 1, 8'h61 + 8'(i), 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h7A, 1);
    cycle(1, 0, 8'h00, 0);

    // Clear wins over a same-cycle write in LOAD
    send("AB", 0);
    cycle(1, 1, 8'h58, 1);
    idle(2);

    // Clear in SCROLL part-way through a step
    send("HELLO", 1);
    idle(6);
    cycle(1, 0, 8'h00, 0);
    idle(1);

    // Gap-style short message (checked against whichever build is active)
    send("AB", 1);
    idle(30);
    cycle(1, 0, 8'h00, 0);

    // Reset mid-message discards the buffer
    send("XYZ", 0);
    do_reset();
    send("QR", 1);
    idle(5);
    cycle(1, 0, 8'h00, 0);

    // Randomized messages with idle gaps and occasional aborts
    for (int n = 0; n < 30; n++) begin
      int len;
      bit aborted;
      len = $urandom_range(1, 18);
      aborted = 0;
      for (int i = 0; i < len && !aborted && !scroll; i++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) cycle(0, 0, 8'(($urandom_range(33, 126))), 0);
        if ($urandom_range(0, 39) == 0) begin
          cycle(1, 1'($urandom_range(0, 1)), 8'h21, 0);
          aborted = 1;
        end else begin
          cycle(0, 1, 8'($urandom_range(33, 126)), (i == len - 1) && ($urandom_range(0, 3) != 0));
        end
      end
      for (int i = 0; i < $urandom_range(0, 40); i++)
        cycle(0, 1'($urandom_range(0, 1)), 8'($urandom_range(33, 126)), 1'($urandom_range(0, 1)));
      cycle(1, 0, 8'h00, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
